// File: rtl/hoene_smart_led_pkg.sv
// rtl/hoene_smart_led_pkg.sv - shared FSM state encoding and word-size default for the smart LED frame path
package hoene_smart_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FORWARD = 2'd2,
        ST_ERROR   = 2'd3
    } frame_state_t;

    localparam int WORD_BITS_DEFAULT = 32;

endpackage

// File: rtl/tt_um_hoene_edge_detect.sv
// rtl/tt_um_hoene_edge_detect.sv - registered-history rising-edge detector
module tt_um_hoene_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev;
    logic primed;

    // Track last level; primed masks the first cycle after reset so a level already high is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= 1'b0;
            primed <= 1'b0;
        end else begin
            prev   <= sig;
            primed <= 1'b1;
        end
    end

    assign rise = primed & sig & ~prev;

endmodule

// File: rtl/tt_um_hoene_frame_controller.sv
// rtl/tt_um_hoene_frame_controller.sv - per-LED frame FSM: capture first word, forward the rest; optional HOENE_FRAME_CTRL_TIMEOUT_EN
module tt_um_hoene_frame_controller
    import hoene_smart_led_pkg::*;
#(
    parameter int WORD_BITS      = WORD_BITS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_data,
    input  logic                         in_clk,
    input  logic                         in_frame,
    input  logic                         in_error,
    output logic                         cap_shift,
    output logic                         cap_data,
    output logic                         fwd_enable,
    output logic                         fwd_data,
    output logic                         fwd_clk,
    output logic                         pwm_store,
    output logic                         error,
    output logic [1:0]                   state,
    output logic [$clog2(WORD_BITS)-1:0] bit_count
);

    localparam int BC_W = $clog2(WORD_BITS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_BITS - 1);

    frame_state_t    state_q, state_d;
    logic [BC_W-1:0] bit_count_q, bit_count_d;
    logic            cap_shift_d, cap_data_d, fwd_clk_d, fwd_data_d, pwm_store_d;
    logic            clk_rise, frame_rise, frame_fall;
    logic            timeout;

    tt_um_hoene_edge_detect u_clk_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (in_clk),
        .rise (clk_rise)
    );

    tt_um_hoene_edge_detect u_frame_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (in_frame),
        .rise (frame_rise)
    );

    // A frame fall is a rise of the inverted frame level
    tt_um_hoene_edge_detect u_frame_fall (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (~in_frame),
        .rise (frame_fall)
    );

`ifdef HOENE_FRAME_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_run;

    assign tmo_run = (state_q == ST_CAPTURE) || (state_q == ST_FORWARD);

    // Cycles since last bit edge (or CAPTURE entry), minus one; idle outside active states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (clk_rise || !tmo_run) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Trip one count early so ERROR shows exactly TIMEOUT_CYCLES cycles after the edge
    assign timeout = tmo_run && !clk_rise && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));
`else
    assign timeout = 1'b0;
`endif

    // State register plus registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_count_q <= '0;
            cap_shift   <= 1'b0;
            cap_data    <= 1'b0;
            fwd_clk     <= 1'b0;
            fwd_data    <= 1'b0;
            pwm_store   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            cap_shift   <= cap_shift_d;
            cap_data    <= cap_data_d;
            fwd_clk     <= fwd_clk_d;
            fwd_data    <= fwd_data_d;
            pwm_store   <= pwm_store_d;
        end
    end

    // Next state: decoder error beats everything, a bit edge is handled before a coincident frame fall
    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_rise) begin
                    state_d     = ST_CAPTURE;
                    bit_count_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (in_error) begin
                    state_d = ST_ERROR;
                end else if (clk_rise) begin
                    if (bit_count_q == LAST_BIT) begin
                        bit_count_d = '0;
                        state_d     = frame_fall ? ST_IDLE : ST_FORWARD;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                        if (frame_fall) begin
                            state_d = ST_ERROR;
                        end
                    end
                end else if (frame_fall || timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_FORWARD: begin
                if (in_error) begin
                    state_d = ST_ERROR;
                end else if (frame_fall) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                if (!in_frame) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Strobe values for next cycle; nothing fires on a transition into ERROR
    always_comb begin
        cap_shift_d = 1'b0;
        cap_data_d  = 1'b0;
        fwd_clk_d   = 1'b0;
        fwd_data_d  = 1'b0;
        pwm_store_d = 1'b0;
        if (state_q == ST_CAPTURE && clk_rise && state_d != ST_ERROR) begin
            cap_shift_d = 1'b1;
            cap_data_d  = in_data;
        end
        if (state_q == ST_FORWARD && clk_rise && state_d != ST_ERROR) begin
            fwd_clk_d  = 1'b1;
            fwd_data_d = in_data;
        end
        if ((state_q == ST_CAPTURE || state_q == ST_FORWARD) && state_d == ST_IDLE) begin
            pwm_store_d = 1'b1;
        end
    end

    assign fwd_enable = (state_q == ST_FORWARD);
    assign error      = (state_q == ST_ERROR);
    assign state      = state_q;
    assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_tt_um_hoene_frame_controller.sv
// tb/tb_tt_um_hoene_frame_controller.sv - randomized directed bench with frame-level reference model
module tb_tt_um_hoene_frame_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_data = 1'b0;
    logic       in_clk = 1'b0;
    logic       in_frame = 1'b0;
    logic       in_error = 1'b0;
    logic       cap_shift, cap_data, fwd_enable, fwd_data, fwd_clk, pwm_store, error;
    logic [1:0] state;
    logic [4:0] bit_count;

    tt_um_hoene_frame_controller #(.WORD_BITS(32), .TIMEOUT_CYCLES(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_clk    (in_clk),
        .in_frame  (in_frame),
        .in_error  (in_error),
        .cap_shift (cap_shift),
        .cap_data  (cap_data),
        .fwd_enable(fwd_enable),
        .fwd_data  (fwd_data),
        .fwd_clk   (fwd_clk),
        .pwm_store (pwm_store),
        .error     (error),
        .state     (state),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int          cap_n, fwd_n, store_n, store_cyc, viol;
    logic [63:0] cap_vec, fwd_vec;
    logic [15:0] st_log;
    logic [1:0]  last_state;
    int          fall_cyc, edge_cyc;

    // Output observer: collects strobes, state trace and invariant violations
    always @(negedge clk) begin
        if (cap_shift) begin
            cap_n++;
            cap_vec = {cap_vec[62:0], cap_data};
        end
        if (fwd_clk) begin
            fwd_n++;
            fwd_vec = {fwd_vec[62:0], fwd_data};
        end
        if (pwm_store) begin
            store_n++;
            store_cyc = cyc;
        end
        if (state !== last_state) begin
            st_log = {st_log[11:0], 2'b00, state};
            last_state = state;
        end
        if (cap_shift && fwd_clk) viol++;
        if (state == 2'd3 && (cap_shift || fwd_clk || fwd_enable || pwm_store)) viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cap_n = 0; fwd_n = 0; store_n = 0; store_cyc = -1; viol = 0;
        cap_vec = '0; fwd_vec = '0; st_log = '0; last_state = state;
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        in_data = b;
        in_clk = 1'b1;
        edge_cyc = cyc;
        @(posedge clk); #1;
        in_clk = 1'b0;
    endtask

    // One frame of n random bits; err_at >= 0 pulses in_error after that bit index
    task automatic run_frame(input string tag, input int n, input int err_at, input bit fall_with_last);
        logic [63:0] bits;
        logic [63:0] ecap, efwd;
        int          ncap, nfwd, fwd_lim;
        bit          good;
        logic [15:0] elog;
        bits = {$urandom, $urandom};
        ecap = '0; efwd = '0;
        good = (err_at < 0) && (n >= 32);
        ncap = (n < 32) ? n : 32;
        fwd_lim = (err_at >= 0) ? err_at + 1 : n;
        nfwd = (fwd_lim > 32) ? fwd_lim - 32 : 0;
        for (int i = 0; i < ncap; i++) ecap = {ecap[62:0], bits[i]};
        for (int i = 32; i < fwd_lim; i++) efwd = {efwd[62:0], bits[i]};
        if (fall_with_last) elog = 16'h0010;
        else if (err_at >= 0) elog = 16'h1230;
        else if (n < 32) elog = 16'h0130;
        else elog = 16'h0120;

        clear_mon();
        @(posedge clk); #1;
        in_frame = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (fall_with_last && i == n - 1) begin
                @(posedge clk); #1;
                in_data = bits[i];
                in_clk = 1'b1;
                in_frame = 1'b0;
                fall_cyc = cyc;
            end else begin
                send_bit(bits[i]);
            end
            if (i == err_at) begin
                in_error = 1'b1;
                @(negedge clk);
                check({tag, "_fwd_en_before_err"}, fwd_enable, 1'b1);
                @(posedge clk); #1;
                in_error = 1'b0;
                @(negedge clk);
                check({tag, "_state_after_err"}, state, 2'd3);
                check({tag, "_fwd_en_after_err"}, fwd_enable, 1'b0);
            end
        end
        if (!fall_with_last) begin
            @(posedge clk); #1;
            in_frame = 1'b0;
            fall_cyc = cyc;
        end
        @(posedge clk); #1;
        in_clk = 1'b0;
        @(negedge clk);
        check({tag, "_error_after_fall"}, error, (n < 32 && err_at < 0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_cap_count"}, cap_n, ncap);
        check({tag, "_cap_bits"}, cap_vec, ecap);
        check({tag, "_fwd_count"}, fwd_n, nfwd);
        check({tag, "_fwd_bits"}, fwd_vec, efwd);
        check({tag, "_store_count"}, store_n, good ? 1 : 0);
        if (good) check({tag, "_store_timing"}, store_cyc - fall_cyc, 1);
        check({tag, "_state_trace"}, st_log, elog);
        check({tag, "_final_state"}, state, 2'd0);
        check({tag, "_invariants"}, viol, 0);
    endtask

    initial begin
        int n;
        clear_mon();
        #1;
        check("reset_outputs",
              {cap_shift, cap_data, fwd_enable, fwd_data, fwd_clk, pwm_store, error, state, bit_count}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bit edges while idle must be ignored
        for (int i = 0; i < 3; i++) send_bit($urandom_range(0, 1));
        @(negedge clk);
        check("idle_edges_ignored", cap_n, 0);
        check("idle_state", state, 2'd0);

        run_frame("f40", 40, -1, 1'b0);
        run_frame("f20", 20, -1, 1'b0);
        run_frame("ferr35", 40, 34, 1'b0);
        run_frame("f32_fall", 32, -1, 1'b1);
        run_frame("f32", 32, -1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n = $urandom_range(33, 60);
            run_frame("frand", n, -1, 1'b0);
        end
        n = $urandom_range(1, 30);
        run_frame("fshort_rand", n, -1, 1'b0);

        // Reset in the middle of a capture
        clear_mon();
        @(posedge clk); #1;
        in_frame = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send_bit($urandom_range(0, 1));
        @(negedge clk);
        check("pre_reset_bit_count", bit_count, 5'd10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {cap_shift, cap_data, fwd_enable, fwd_data, fwd_clk, pwm_store, error, state, bit_count}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        for (int i = 0; i < 5; i++) send_bit($urandom_range(0, 1));
        @(negedge clk);
        check("post_reset_no_cap", cap_n, 0);
        check("post_reset_no_store", store_n, 0);
        check("post_reset_idle", state, 2'd0);
        @(posedge clk); #1;
        in_frame = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_frame("f_after_reset", 36, -1, 1'b0);

`ifdef HOENE_FRAME_CTRL_TIMEOUT_EN
        begin
            int err_cyc;
            clear_mon();
            err_cyc = -1;
            @(posedge clk); #1;
            in_frame = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) send_bit($urandom_range(0, 1));
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (state == 2'd3) begin
                    err_cyc = cyc;
                    break;
                end
            end
            check("timeout_latency", err_cyc - edge_cyc, 255);
            @(posedge clk); #1;
            in_frame = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("timeout_recover", state, 2'd0);
            check("timeout_no_store", store_n, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_hoene_frame_controller.md
TT_UM_HOENE_FRAME_CONTROLLER -- requirements
Module: tt_um_hoene_frame_controller

Interface
REQ-001 Parameter WORD_BITS, default 32: bits captured for this LED per frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: max clk cycles between bit edges inside a frame.
REQ-003 The block SHALL have exactly one clock and an asynchronous, active-low reset:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  1  decoded bit, valid at in_clk rising edge.
- in_clk  in  1  decoded bit clock level, synchronous to clk.
- in_frame  in  1  frame active level from framing.
- in_error  in  1  decoder error level.
- cap_shift  out  1  one-cycle strobe to serial2parallel.
- cap_data  out  1  bit accompanying cap_shift.
- fwd_enable  out  1  downstream encoder drive enable.
- fwd_data  out  1  forwarded bit.
- fwd_clk  out  1  forwarded bit strobe.
- pwm_store  out  1  one-cycle strobe to latch the captured word into PWM.
- error  out  1  high while in ERROR.
- state  out  2  current FSM state.
- bit_count  out  $clog2(WORD_BITS)  captured-bit index.

Function
REQ-004 A bit edge SHALL be in_clk high in a cycle where in_clk was low in the previous cycle; a frame rise or fall SHALL be detected the same way on in_frame.
REQ-005 FSM states SHALL be IDLE=0, CAPTURE=1, FORWARD=2, ERROR=3.
REQ-006 In IDLE, a frame rise SHALL move to CAPTURE and clear bit_count; bit edges in IDLE SHALL be ignored.
REQ-007 In CAPTURE, each bit edge SHALL assert cap_shift for one cycle, registered one cycle after the edge, with cap_data equal to in_data sampled at the edge, and SHALL increment bit_count.
REQ-008 The bit edge when bit_count equals WORD_BITS-1 SHALL be captured, bit_count SHALL wrap to 0, and the FSM SHALL move to FORWARD.
REQ-009 In FORWARD, fwd_enable SHALL be 1 and each bit edge SHALL produce a one-cycle fwd_clk with fwd_data, at one cycle latency.
REQ-010 A frame fall in FORWARD SHALL pulse pwm_store for one cycle, clear fwd_enable, and move to IDLE.
REQ-011 A frame fall in CAPTURE (short frame) SHALL move to ERROR and SHALL NOT pulse pwm_store.
REQ-012 in_error high in CAPTURE or FORWARD SHALL move to ERROR the next cycle.
REQ-013 In ERROR, cap_shift, fwd_clk, fwd_enable and pwm_store SHALL all be 0.
REQ-014 ERROR SHALL move to IDLE on the first cycle in_frame is low.
REQ-015 Simultaneous events SHALL be resolved in this priority order:
- in_error beats frame fall, so there is no store.
- A bit edge in the same cycle as a frame fall is processed first; if it completes the word, pwm_store is still pulsed.
REQ-016 cap_shift and fwd_clk SHALL never be high in the same cycle.

Reset
REQ-017 rst_n low SHALL asynchronously force state=IDLE, bit_count=0, and all outputs 0, including the edge-detector history registers.
REQ-018 Reset asserted mid-frame SHALL abandon the frame with no pwm_store.
REQ-019 After reset release, a frame already in progress (in_frame high) SHALL be ignored until a new frame rise.

Configuration
REQ-020 With HOENE_FRAME_CTRL_TIMEOUT_EN defined, a cycle counter SHALL behave as follows:
- It clears on every bit edge and on entry to CAPTURE.
- It counts in CAPTURE and FORWARD.
- On reaching TIMEOUT_CYCLES, the FSM SHALL move to ERROR.
REQ-021 Without HOENE_FRAME_CTRL_TIMEOUT_EN, no timeout logic SHALL exist and TIMEOUT_CYCLES SHALL be ignored.

Structure
REQ-022 The shared package hoene_smart_led_pkg SHALL hold the FSM state type and encodings, plus the WORD_BITS default constant.
REQ-023 Rising-edge detection SHALL be one reusable sub-module, tt_um_hoene_edge_detect, instantiated for in_clk and for in_frame.

Verification
REQ-024 Frame with 40 bits, no error:
- Exactly 32 cap_shift pulses.
- 8 fwd_clk pulses.
- One pwm_store, one cycle after the frame fall.
- state sequence 0->1->2->0.
REQ-025 Frame with 20 bits: 20 cap_shift pulses, no pwm_store, error=1 after the fall, back in IDLE when in_frame is low.
REQ-026 in_error pulse at bit 35: state=3, fwd_enable drops the next cycle, no pwm_store.
REQ-027 32nd bit edge in the same cycle as the frame fall: 32 cap_shift pulses and one pwm_store.
REQ-028 rst_n low at bit 10 of a frame: all outputs 0 immediately; after release with in_frame high, no cap_shift until the next frame rise.
REQ-029 With the macro defined and TIMEOUT_CYCLES=255, stalling in_clk for 300 cycles in CAPTURE: state=3 exactly 255 cycles after the last edge.
